// File: rtl/psum_acc_pkg.sv
// psum_acc_pkg: shared definitions for the partial-sum accumulator controller.
//   - controller state encoding
//   - bit positions of the fields inside mac_array2psum_acc_info
//   - default sizing parameters
//   - packed view of the used info fields
package psum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // mac_array2psum_acc_info layout; bits above HALF_BIT carry no meaning here
    localparam int HALF_BIT = 13;
    localparam int GRP_BIT  = 12;
    localparam int OFF_MSB  = 11;
    localparam int OFF_LSB  = 0;
    localparam int OFF_W    = OFF_MSB - OFF_LSB + 1;
    localparam int ADDR_W   = OFF_W + 1;

    localparam int DEF_LANES     = 32;
    localparam int DEF_PSUM_W    = 24;
    localparam int DEF_OMAP_SIZE = 3136;
    localparam int DEF_NGRP      = 4;

    typedef struct packed {
        logic             half;
        logic             grp;
        logic [OFF_W-1:0] off;
    } info_t;

endpackage

// File: rtl/psum_lane_add.sv
// psum_lane_add: one signed lane adder, sum = a + b, PSUM_W bits wide.
//   Ports: a, b (signed operands), sum (result).
//   Build option PSUM_ACC_SAT_EN: clamp to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1];
//   otherwise the sum wraps modulo 2^PSUM_W. Purely combinational either way.
module psum_lane_add
    import psum_acc_pkg::*;
#(
    parameter int PSUM_W = DEF_PSUM_W
) (
    input  logic [PSUM_W-1:0] a,
    input  logic [PSUM_W-1:0] b,
    output logic [PSUM_W-1:0] sum
);

`ifdef PSUM_ACC_SAT_EN
    logic [PSUM_W:0] full;

    // One guard bit: overflow whenever the guard and the top result bit disagree
    assign full = {a[PSUM_W-1], a} + {b[PSUM_W-1], b};

    always_comb begin
        sum = full[PSUM_W-1:0];
        if (full[PSUM_W] != full[PSUM_W-1])
            sum = full[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}}
                               : {1'b0, {(PSUM_W-1){1'b1}}};
    end
`else
    assign sum = a + b;
`endif

endmodule

// File: rtl/psum_acc_ctrl.sv
// psum_acc_ctrl: receives partial-sum beats from the MAC array. Group-0 beats
// are written straight into the external psum buffer; group-1 beats read the
// stored value back and emit the lane-wise sum downstream.
//   clk, rst                     clock, async active-high reset
//   acc_start                    start pulse (honoured only in IDLE)
//   mac_array2psum_acc_vld/rdy   input handshake
//   mac_array2psum_acc_data/info input beat payload and tag
//   psum_buf_wen/ren/addr/wdata  buffer access strobes (never both at once)
//   psum_buf_rdata               buffer read data, one cycle after ren
//   acc_out_vld/rdy/data/info    result handshake and payload
//   acc_done                     one-cycle completion pulse
// Build option PSUM_ACC_SAT_EN selects saturating lane adds (see psum_lane_add).
module psum_acc_ctrl
    import psum_acc_pkg::*;
#(
    parameter int LANES     = DEF_LANES,
    parameter int PSUM_W    = DEF_PSUM_W,
    parameter int OMAP_SIZE = DEF_OMAP_SIZE,
    parameter int NGRP      = DEF_NGRP
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    acc_start,
    input  logic                    mac_array2psum_acc_vld,
    output logic                    mac_array2psum_acc_rdy,
    input  logic [LANES*PSUM_W-1:0] mac_array2psum_acc_data,
    input  logic [31:0]             mac_array2psum_acc_info,
    output logic                    psum_buf_wen,
    output logic                    psum_buf_ren,
    output logic [ADDR_W-1:0]       psum_buf_addr,
    output logic [LANES*PSUM_W-1:0] psum_buf_wdata,
    input  logic [LANES*PSUM_W-1:0] psum_buf_rdata,
    output logic                    acc_out_vld,
    input  logic                    acc_out_rdy,
    output logic [LANES*PSUM_W-1:0] acc_out_data,
    output logic [ADDR_W-1:0]       acc_out_info,
    output logic                    acc_done
);

    localparam logic [11:0] BEAT_LAST = 12'(OMAP_SIZE - 1);
    localparam logic [2:0]  MAP_LAST  = 3'(NGRP - 1);

    state_t state, state_nxt;
    logic   run_st;
    logic [11:0] beat_cnt;
    logic [2:0]  map_cnt;
    logic        pe, in_acc, last_beat;
    info_t       in_info;
    logic        info_unused;

    logic                           s1_vld;
    logic [LANES-1:0][PSUM_W-1:0]   s1_data;
    logic [ADDR_W-1:0]              s1_info;
    logic                           rd_pend;
    logic [LANES-1:0][PSUM_W-1:0]   rd_hold, rd_opnd, lane_sum;

    assign in_info = '{half: mac_array2psum_acc_info[HALF_BIT],
                       grp:  mac_array2psum_acc_info[GRP_BIT],
                       off:  mac_array2psum_acc_info[OFF_MSB:OFF_LSB]};
    assign info_unused = ^mac_array2psum_acc_info[31:HALF_BIT+1];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc_start) state_nxt = RUN;
            RUN:     if (last_beat) state_nxt = DRAIN;
            DRAIN:   if (!s1_vld && !acc_out_vld) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        run_st   = (state == RUN);
        acc_done = (state == DONE);
    end

    // ---------------- handshake ----------------
    // The whole pipeline advances together; a full, unaccepted output
    // register freezes S1 and the hold register and closes the input.
    assign pe                     = !acc_out_vld || acc_out_rdy;
    assign mac_array2psum_acc_rdy = run_st && pe;
    assign in_acc                 = mac_array2psum_acc_vld && mac_array2psum_acc_rdy;
    assign last_beat              = in_acc && (beat_cnt == BEAT_LAST) && (map_cnt == MAP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            map_cnt  <= '0;
        end else if (state == IDLE && acc_start) begin
            beat_cnt <= '0;
            map_cnt  <= '0;
        end else if (in_acc) begin
            if (beat_cnt == BEAT_LAST) begin
                beat_cnt <= '0;
                map_cnt  <= (map_cnt == MAP_LAST) ? '0 : map_cnt + 3'd1;
            end else begin
                beat_cnt <= beat_cnt + 12'd1;
            end
        end
    end

    // ---------------- buffer port ----------------
    // Address/data are zeroed when idle so the bus is quiet between beats.
    assign psum_buf_wen   = in_acc && !in_info.grp;
    assign psum_buf_ren   = in_acc &&  in_info.grp;
    assign psum_buf_addr  = in_acc ? {in_info.half, in_info.off} : '0;
    assign psum_buf_wdata = psum_buf_wen ? mac_array2psum_acc_data : '0;

    // ---------------- S1 + read hold ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
            s1_info <= '0;
            rd_pend <= 1'b0;
            rd_hold <= '0;
        end else begin
            rd_pend <= psum_buf_ren;
            if (rd_pend)
                rd_hold <= psum_buf_rdata;
            if (psum_buf_ren) begin
                s1_vld  <= 1'b1;
                s1_data <= mac_array2psum_acc_data;
                s1_info <= psum_buf_addr;
            end else if (pe) begin
                s1_vld  <= 1'b0;
            end
        end
    end

    // Read data is live only in the cycle after ren; bypass it then so an
    // unstalled beat reaches the output two cycles after acceptance.
    assign rd_opnd = rd_pend ? psum_buf_rdata : rd_hold;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        psum_lane_add #(.PSUM_W(PSUM_W)) u_add (
            .a   (s1_data[i]),
            .b   (rd_opnd[i]),
            .sum (lane_sum[i])
        );
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out_vld  <= 1'b0;
            acc_out_data <= '0;
            acc_out_info <= '0;
        end else if (s1_vld && pe) begin
            acc_out_vld  <= 1'b1;
            acc_out_data <= lane_sum;
            acc_out_info <= s1_info;
        end else if (acc_out_rdy) begin
            acc_out_vld  <= 1'b0;
        end
    end

endmodule

// File: doc/psum_acc_ctrl.md
# psum_acc_ctrl

Receiving end of the MAC-array → partial-sum-accumulator valid/ready interface. Accepts per-pixel partial-sum vectors tagged with `mac_array2psum_acc_info`, stores first-input-channel-group results in an external psum buffer, and adds second-group results to the stored values. It emits completed output-map vectors downstream and applies backpressure to the MAC array through `mac_array2psum_acc_rdy`.

## Interface
Parameters:
- `LANES`, 32: output channels per beat.
- `PSUM_W`, 24: signed psum width per lane.
- `OMAP_SIZE`, 3136: pixels per 2-D output map (56x56).
- `NGRP`, 4: maps per conv, i.e. accepted map passes before done (2*NOCH).

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `acc_start`  in  1  one-cycle start pulse.
- `mac_array2psum_acc_vld`  in  1  input beat valid.
- `mac_array2psum_acc_rdy`  out  1  input beat ready.
- `mac_array2psum_acc_data`  in  LANES*PSUM_W  lane i at bits [i*PSUM_W +: PSUM_W].
- `mac_array2psum_acc_info`  in  32  [13] out-ch half, [12] in-ch group, [11:0] pixel offset; [31:14] ignored.
- `psum_buf_wen`, `psum_buf_ren`  out  1  buffer write and read strobes.
- `psum_buf_addr`  out  13  {info[13], offset}; shared by read and write.
- `psum_buf_wdata`  out  LANES*PSUM_W  write data.
- `psum_buf_rdata`  in  LANES*PSUM_W  valid exactly one cycle after `psum_buf_ren`.
- `acc_out_vld`  out  1  result valid.
- `acc_out_rdy`  in  1  result ready.
- `acc_out_data`  out  LANES*PSUM_W  accumulated result.
- `acc_out_info`  out  13  {out-ch half, offset}.
- `acc_done`  out  1  one-cycle completion pulse.

## Operation
- State machine: IDLE → RUN on `acc_start`. RUN → DRAIN on acceptance of the last beat: `beat_cnt==OMAP_SIZE-1` and `map_cnt==NGRP-1`. DRAIN → DONE when stage S1 and the output register are both empty. DONE → IDLE unconditionally, with `acc_done`=1 for that cycle.
- Counters:
  - `beat_cnt` (12b) wraps at OMAP_SIZE-1.
  - `map_cnt` (3b) increments on each `beat_cnt` wrap and wraps at NGRP-1.
  - Both advance only on accepted beats and clear on `acc_start`.
- Pipeline enable: `pe = !acc_out_vld || acc_out_rdy`.
- `mac_array2psum_acc_rdy = (state==RUN) && pe`. A beat is accepted when vld && rdy.
- Group-0 beat (info[12]=0):
  - Same cycle: `psum_buf_wen`=1, `wdata`=data, `addr`={info[13],offset}.
  - Nothing propagates downstream.
- Group-1 beat (info[12]=1):
  - Same cycle: `psum_buf_ren`=1 at that address. Data and info are captured into S1, and `s1_vld` is set.
  - Next cycle: `psum_buf_rdata` is unconditionally captured into a hold register.
  - When S1 is valid and `pe`=1: output register ← lane-wise S1 data + held rdata, info ← S1 info, `acc_out_vld`=1.
- `wen` and `ren` are never asserted in the same cycle.
- Output register clears `acc_out_vld` when `acc_out_rdy`=1 and S1 is empty.
- Arithmetic: signed two's complement per lane, result PSUM_W bits. Default behaviour wraps (overflow bits dropped).
- Info bits [31:14] are ignored. Beats presented while not in RUN are not accepted (rdy=0).
- Reset mid-operation: all state returns to reset values immediately. Any in-flight S1 or output beat is discarded.
- `acc_start` while not in IDLE is ignored.

## Timing
- Reset values: `mac_array2psum_acc_rdy`=0, `psum_buf_wen`=0, `psum_buf_ren`=0, `psum_buf_addr`=0, `psum_buf_wdata`=0, `acc_out_vld`=0, `acc_out_data`=0, `acc_out_info`=0, `acc_done`=0, state IDLE.
- `rdy` rises the cycle after `acc_start` is sampled.
- Group-1 latency: accept at cycle N → `acc_out_vld` at N+2 with no stall.
- Sustained throughput: 1 beat/cycle while `acc_out_rdy`=1.
- Stall: `acc_out_rdy`=0 with output full drops `rdy` combinationally in the same cycle. S1 and the hold register keep their contents, and no beat is lost.
- `acc_done` is asserted 1 cycle after the last output is taken, or 1 cycle after the last group-0 write if the final map is group 0.

## Configuration
- `PSUM_ACC_SAT_EN` defined: each lane sum saturates to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1].
- Undefined: each lane sum wraps modulo 2^PSUM_W.
- Latency is identical either way.

## Structure
- Shared package `psum_acc_pkg`:
  - state encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3.
  - info field bit positions: HALF_BIT=13, GRP_BIT=12, OFFSET range 11:0.
  - default LANES, PSUM_W, OMAP_SIZE.
- Sub-module `psum_lane_add`: one signed PSUM_W adder with the optional saturation. It is instantiated LANES times via generate.

## Test plan
- Group-0 beat, info=0x0000_0005, lane0=100 → `wen`=1 and addr=0x0005 that cycle; `acc_out_vld` stays 0.
- Group-1 beat, info=0x0000_1005, lane0=23, with buffer returning lane0=100 → `acc_out_vld` 2 cycles later, lane0=123, `acc_out_info`=0x005.
- Hold `acc_out_rdy`=0 for 5 cycles during a group-1 stream → `rdy` low the same cycles; output sequence is complete and in order after release.
- Wrap versus saturation: lane values 0x7FFFFF + 1 → 0x800000 without `PSUM_ACC_SAT_EN`, 0x7FFFFF with it.
- Full run with OMAP_SIZE=4, NGRP=4 and alternating groups → exactly 8 outputs, then a single-cycle `acc_done`, then IDLE.
- Assert `rst` with S1 and the output register full → `acc_out_vld` and `rdy` are 0 immediately; after release, a new `acc_start` runs cleanly.
